// File: rtl/multi_pulse_generator_pkg.sv
// pulse_gen_pkg: shared types for the multi-channel pulse generator.
// FSM state enum, channel config struct, default counter widths.
package pulse_gen_pkg;

    localparam int PG_CNT_W   = 16;
    localparam int PG_COUNT_W = 8;

    typedef enum logic [1:0] {
        PG_IDLE,
        PG_WAIT,
        PG_ACTIVE,
        PG_GAP
    } pg_state_e;

    typedef struct packed {
        logic [PG_CNT_W-1:0]   delay;
        logic [PG_CNT_W-1:0]   width;
        logic [PG_CNT_W-1:0]   period;
        logic [PG_COUNT_W-1:0] count;
        logic                  idle;
    } pulse_cfg_t;

    function automatic int pg_ch_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/multi_pulse_generator_if.sv
// multi_pulse_generator_if: config port, start/stop strobes and outputs.
// master drives cfg_*/start/stop and reads pulse/busy/done; slave is the DUT.
interface multi_pulse_generator_if
    import pulse_gen_pkg::*;
#(
    parameter int NUM_CH  = 4,
    parameter int CNT_W   = PG_CNT_W,
    parameter int COUNT_W = PG_COUNT_W
);
    localparam int CH_W = pg_ch_w(NUM_CH);

    logic               cfg_we;
    logic [CH_W-1:0]    cfg_ch;
    logic [CNT_W-1:0]   cfg_delay;
    logic [CNT_W-1:0]   cfg_width;
    logic [CNT_W-1:0]   cfg_period;
    logic [COUNT_W-1:0] cfg_count;
    logic               cfg_idle;
    logic [NUM_CH-1:0]  start;
    logic [NUM_CH-1:0]  stop;
    logic [NUM_CH-1:0]  pulse;
    logic [NUM_CH-1:0]  busy;
    logic [NUM_CH-1:0]  done;

    modport master (
        output cfg_we, cfg_ch, cfg_delay, cfg_width, cfg_period,
        output cfg_count, cfg_idle, start, stop,
        input  pulse, busy, done
    );

    modport slave (
        input  cfg_we, cfg_ch, cfg_delay, cfg_width, cfg_period,
        input  cfg_count, cfg_idle, start, stop,
        output pulse, busy, done
    );

endinterface

// File: rtl/pulse_gen_channel.sv
// pulse_gen_channel: one channel - shadow config, FSM, counters, output regs.
// Ports: clk_in, rst_n (sync, active-low), cfg_we_i/cfg_i shadow write,
// start_i/stop_i strobes, pulse_o/busy_o/done_o registered outputs.
// MULTI_PULSE_GEN_REPEAT_EN builds period/count registers and the GAP state.
module pulse_gen_channel
    import pulse_gen_pkg::*;
(
    input  logic       clk_in,
    input  logic       rst_n,
    input  logic       cfg_we_i,
    input  pulse_cfg_t cfg_i,
    input  logic       start_i,
    input  logic       stop_i,
    output logic       pulse_o,
    output logic       busy_o,
    output logic       done_o
);
    // One extra bit so an effective period of width+1 always fits.
    localparam int CW = PG_CNT_W + 1;

    logic [PG_CNT_W-1:0] sh_delay_q;
    logic [PG_CNT_W-1:0] sh_width_q;
    logic                sh_idle_q;
    logic [PG_CNT_W-1:0] delay_q;
    logic [PG_CNT_W-1:0] width_q;
    logic [CW-1:0]       cnt_q;
    logic [CW-1:0]       cnt_inc;
    logic                idle_q;
    logic                pulse_q;
    logic                busy_q;
    logic                done_q;
    pg_state_e           state_q;
    logic                last_pulse;

`ifdef MULTI_PULSE_GEN_REPEAT_EN
    localparam int NW = PG_COUNT_W + 1;

    logic [PG_CNT_W-1:0]   sh_period_q;
    logic [PG_COUNT_W-1:0] sh_count_q;
    logic [PG_COUNT_W-1:0] count_q;
    logic [PG_COUNT_W-1:0] pcnt_q;
    logic [CW-1:0]         period_q;
    logic [CW-1:0]         per_eff;

    // Stretch the period so at least one gap cycle follows every pulse.
    assign per_eff = ({1'b0, sh_period_q} > {1'b0, sh_width_q})
                   ? {1'b0, sh_period_q}
                   : {1'b0, sh_width_q} + CW'(1);

    // count == 0 is a continuous train: never the last pulse.
    assign last_pulse = (count_q != '0) &&
                        ((NW'(pcnt_q) + NW'(1)) >= NW'(count_q));
`else
    logic unused_cfg;

    assign unused_cfg = ^{cfg_i.period, cfg_i.count};
    assign last_pulse = 1'b1;
`endif

    // Saturating step: counters never wrap.
    assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + CW'(1);

    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            sh_delay_q  <= '0;
            sh_width_q  <= '0;
            sh_idle_q   <= 1'b0;
`ifdef MULTI_PULSE_GEN_REPEAT_EN
            sh_period_q <= '0;
            sh_count_q  <= '0;
`endif
        end else if (cfg_we_i) begin
            sh_delay_q  <= cfg_i.delay;
            sh_width_q  <= cfg_i.width;
            sh_idle_q   <= cfg_i.idle;
`ifdef MULTI_PULSE_GEN_REPEAT_EN
            sh_period_q <= cfg_i.period;
            sh_count_q  <= cfg_i.count;
`endif
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            state_q  <= PG_IDLE;
            cnt_q    <= '0;
            delay_q  <= '0;
            width_q  <= '0;
            idle_q   <= 1'b0;
            pulse_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef MULTI_PULSE_GEN_REPEAT_EN
            period_q <= '0;
            count_q  <= '0;
            pcnt_q   <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            if (stop_i) begin
                state_q <= PG_IDLE;
                busy_q  <= 1'b0;
                pulse_q <= idle_q;
            end else begin
                unique case (state_q)
                    PG_IDLE: begin
                        if (start_i) begin
                            // Working copy; shadow writes this edge land later.
                            delay_q <= sh_delay_q;
                            width_q <= sh_width_q;
                            idle_q  <= sh_idle_q;
                            cnt_q   <= CW'(1);
`ifdef MULTI_PULSE_GEN_REPEAT_EN
                            period_q <= per_eff;
                            count_q  <= sh_count_q;
                            pcnt_q   <= '0;
`endif
                            if (sh_width_q == '0) begin
                                done_q  <= 1'b1;
                                pulse_q <= sh_idle_q;
                            end else if (sh_delay_q == '0) begin
                                state_q <= PG_ACTIVE;
                                busy_q  <= 1'b1;
                                pulse_q <= ~sh_idle_q;
                            end else begin
                                state_q <= PG_WAIT;
                                busy_q  <= 1'b1;
                                pulse_q <= sh_idle_q;
                            end
                        end
                    end
                    PG_WAIT: begin
                        if (cnt_q >= {1'b0, delay_q}) begin
                            state_q <= PG_ACTIVE;
                            pulse_q <= ~idle_q;
                            cnt_q   <= CW'(1);
                        end else begin
                            cnt_q <= cnt_inc;
                        end
                    end
                    PG_ACTIVE: begin
                        if (cnt_q >= {1'b0, width_q}) begin
                            pulse_q <= idle_q;
                            if (last_pulse) begin
                                state_q <= PG_IDLE;
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                            end
`ifdef MULTI_PULSE_GEN_REPEAT_EN
                            else begin
                                // cnt keeps counting from the pulse start.
                                state_q <= PG_GAP;
                                cnt_q   <= cnt_inc;
                                if (count_q != '0) begin
                                    pcnt_q <= pcnt_q + 1'b1;
                                end
                            end
`endif
                        end else begin
                            cnt_q <= cnt_inc;
                        end
                    end
`ifdef MULTI_PULSE_GEN_REPEAT_EN
                    PG_GAP: begin
                        if (cnt_q >= period_q) begin
                            state_q <= PG_ACTIVE;
                            pulse_q <= ~idle_q;
                            cnt_q   <= CW'(1);
                        end else begin
                            cnt_q <= cnt_inc;
                        end
                    end
`endif
                    default: begin
                        state_q <= PG_IDLE;
                        busy_q  <= 1'b0;
                        pulse_q <= idle_q;
                    end
                endcase
            end
        end
    end

    assign pulse_o = pulse_q;
    assign busy_o  = busy_q;
    assign done_o  = done_q;

endmodule

// File: rtl/multi_pulse_generator.sv
// multi_pulse_generator: NUM_CH independent programmable pulse channels.
// Ports: clk_in, rst_n (sync, active-low), bus (slave): cfg write port,
// start/stop strobes, pulse/busy/done outputs. Repeat support is built
// under MULTI_PULSE_GEN_REPEAT_EN. CNT_W/COUNT_W up to the package widths.
module multi_pulse_generator
    import pulse_gen_pkg::*;
#(
    parameter int NUM_CH  = 4,
    parameter int CNT_W   = PG_CNT_W,
    parameter int COUNT_W = PG_COUNT_W
)
(
    input  logic                     clk_in,
    input  logic                     rst_n,
    multi_pulse_generator_if.slave   bus
);
    localparam int CH_W = pg_ch_w(NUM_CH);

    pulse_cfg_t        cfg_s;
    logic [NUM_CH-1:0] pulse_v;
    logic [NUM_CH-1:0] busy_v;
    logic [NUM_CH-1:0] done_v;

    always_comb begin
        cfg_s        = '0;
        cfg_s.delay  = PG_CNT_W'(bus.cfg_delay);
        cfg_s.width  = PG_CNT_W'(bus.cfg_width);
        cfg_s.period = PG_CNT_W'(bus.cfg_period);
        cfg_s.count  = PG_COUNT_W'(bus.cfg_count);
        cfg_s.idle   = bus.cfg_idle;
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        // Indices at or above NUM_CH match no channel and are dropped.
        pulse_gen_channel u_ch (
            .clk_in   (clk_in),
            .rst_n    (rst_n),
            .cfg_we_i (bus.cfg_we && (bus.cfg_ch == CH_W'(i))),
            .cfg_i    (cfg_s),
            .start_i  (bus.start[i]),
            .stop_i   (bus.stop[i]),
            .pulse_o  (pulse_v[i]),
            .busy_o   (busy_v[i]),
            .done_o   (done_v[i])
        );
    end

    assign bus.pulse = pulse_v;
    assign bus.busy  = busy_v;
    assign bus.done  = done_v;

endmodule
